// File: rtl/tpfu_operand_loader_pkg.sv
// Shared definitions for the TP-FU operand loader: emit FSM states, default
// sizing and the gap floor tied to the FU program length.
package tpfu_operand_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } emit_state_t;

    localparam int TPFU_DATA_W         = 16;
    localparam int TPFU_BURST_LEN      = 4;
    localparam int TPFU_FU_INSTR_COUNT = 7;
    localparam int TPFU_MIN_GAP        = TPFU_FU_INSTR_COUNT + 5;

    // Index width that never collapses to zero bits for tiny depths.
    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tpfu_operand_loader_buffer.sv
// Operand store for one burst: each host word fills an even/odd operand pair,
// and the emit side reads one operand per cycle by index.
module tpfu_operand_loader_buffer
    import tpfu_operand_loader_pkg::*;
#(
    parameter int BURST_LEN = TPFU_BURST_LEN,
    parameter int DATA_W    = TPFU_DATA_W,
    parameter int WA        = addr_w(BURST_LEN / 2),
    parameter int RA        = addr_w(BURST_LEN)
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [WA-1:0]       wr_word,
    input  logic [2*DATA_W-1:0] wr_data,
    input  logic [RA-1:0]       rd_addr,
    output logic [DATA_W-1:0]   rd_data
);

    logic [DATA_W-1:0] mem [BURST_LEN];
    logic [RA-1:0]     lo_idx;
    logic [RA-1:0]     hi_idx;

    assign lo_idx = RA'({wr_word, 1'b0});
    assign hi_idx = lo_idx | RA'(1);

    // Low half of the host word is the lower operand address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[lo_idx] <= wr_data[DATA_W-1:0];
            mem[hi_idx] <= wr_data[2*DATA_W-1:DATA_W];
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tpfu_operand_loader.sv
// Feeds the TP-FU: gathers host FIFO words into a burst buffer, then emits the
// operands as one unbroken valid burst followed by a fixed idle gap.
module tpfu_operand_loader
    import tpfu_operand_loader_pkg::*;
#(
    parameter int BURST_LEN  = TPFU_BURST_LEN,
    parameter int GAP_CYCLES = TPFU_MIN_GAP,
    parameter int DATA_W     = TPFU_DATA_W,
    parameter int IN_W       = 2 * DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [IN_W-1:0]   fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] din,
    output logic              valid,
    output logic              busy,
    output logic              burst_done,
    output logic [15:0]       burst_cnt
);

    localparam int WORDS = BURST_LEN / 2;
    localparam int WA    = addr_w(WORDS);
    localparam int RA    = addr_w(BURST_LEN);
    localparam int GW    = addr_w(GAP_CYCLES);

    emit_state_t       state;
    logic [WA:0]       req_cnt;
    logic [WA:0]       cap_cnt;
    logic              rd_pending;
    logic              buf_full;
    logic [RA:0]       emit_idx;
    logic [GW-1:0]     gap_cnt;
    logic [DATA_W-1:0] buf_rd_data;
    logic              last_capture;
    logic              gap_last;
    logic              start_emit;

    // Refill is held off during EMIT so the operands being emitted stay intact.
    assign fifo_rd_en   = !rst && !fifo_empty && !buf_full && enable
                        && (state != EMIT) && (req_cnt < (WA+1)'(WORDS));
    assign last_capture = rd_pending && (cap_cnt == (WA+1)'(WORDS - 1));
    assign gap_last     = (gap_cnt == GW'(GAP_CYCLES - 1));
    assign start_emit   = buf_full && enable
                        && ((state == IDLE) || ((state == GAP) && gap_last));
    assign busy         = (state != IDLE);

    tpfu_operand_loader_buffer #(
        .BURST_LEN (BURST_LEN),
        .DATA_W    (DATA_W),
        .WA        (WA),
        .RA        (RA)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (rd_pending),
        .wr_word (cap_cnt[WA-1:0]),
        .wr_data (fifo_dout),
        .rd_addr (emit_idx[RA-1:0]),
        .rd_data (buf_rd_data)
    );

    // Read data arrives one cycle after the strobe; a read in flight at reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_cnt    <= '0;
            cap_cnt    <= '0;
            rd_pending <= 1'b0;
            buf_full   <= 1'b0;
        end else begin
            rd_pending <= fifo_rd_en;
            if (fifo_rd_en) begin
                req_cnt <= req_cnt + 1'b1;
            end
            if (rd_pending) begin
                if (last_capture) begin
                    cap_cnt  <= '0;
                    req_cnt  <= '0;
                    buf_full <= 1'b1;
                end else begin
                    cap_cnt <= cap_cnt + 1'b1;
                end
            end
            if (start_emit) begin
                buf_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            emit_idx   <= '0;
            gap_cnt    <= '0;
            valid      <= 1'b0;
            din        <= '0;
            burst_done <= 1'b0;
            burst_cnt  <= '0;
        end else begin
            burst_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_emit) begin
                        state    <= EMIT;
                        valid    <= 1'b1;
                        din      <= buf_rd_data;
                        emit_idx <= (RA+1)'(1);
                    end
                end
                EMIT: begin
                    if (emit_idx == (RA+1)'(BURST_LEN)) begin
                        state    <= GAP;
                        valid    <= 1'b0;
                        din      <= '0;
                        emit_idx <= '0;
                        gap_cnt  <= '0;
                    end else begin
                        din      <= buf_rd_data;
                        emit_idx <= emit_idx + 1'b1;
                    end
                end
                GAP: begin
                    // Registered pulse lands on the final gap cycle.
                    if (gap_cnt == GW'(GAP_CYCLES - 2)) begin
                        burst_done <= 1'b1;
                        burst_cnt  <= burst_cnt + 16'd1;
                    end
                    if (gap_last) begin
                        gap_cnt <= '0;
                        if (start_emit) begin
                            state    <= EMIT;
                            valid    <= 1'b1;
                            din      <= buf_rd_data;
                            emit_idx <= (RA+1)'(1);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpfu_operand_loader.sv
// Bench for tpfu_operand_loader: a FIFO model plus an operand-stream and
// burst-timing monitor, with directed scenarios that pin literal values.
module tb_tpfu_operand_loader;

    localparam int BURST_LEN  = 4;
    localparam int GAP_CYCLES = 12;
    localparam int DATA_W     = 16;
    localparam int IN_W       = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic [IN_W-1:0]   fifo_dout = '0;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] din;
    logic              valid;
    logic              busy;
    logic              burst_done;
    logic [15:0]       burst_cnt;

    logic [IN_W-1:0] fifo_mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;

    int errors = 0;
    int checks = 0;

    int exp_word = 0;
    int exp_half = 0;
    int run_len = 0;
    int low_cnt = 0;
    int exp_bursts = 0;
    int last_gap = -1;
    int gap_reads = 0;
    bit tracking = 1'b0;
    bit rst_prev = 1'b1;

    tpfu_operand_loader #(
        .BURST_LEN  (BURST_LEN),
        .GAP_CYCLES (GAP_CYCLES),
        .DATA_W     (DATA_W),
        .IN_W       (IN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .din        (din),
        .valid      (valid),
        .busy       (busy),
        .burst_done (burst_done),
        .burst_cnt  (burst_cnt)
    );

    always #5 clk = ~clk;

    // Host FIFO: data appears the cycle after the read strobe.
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= fifo_mem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] words, input int n);
        @(posedge clk);
        #1;
        for (int k = 0; k < n; k++) begin
            fifo_mem[wr_ptr % 64] = words[32*k +: 32];
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitValid(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: valid still 0 after 200 cycles, want 1", name);
        end
    endtask

    task automatic expectBurst(input string name, input logic [63:0] ops);
        bit ok;
        waitValid(name, ok);
        if (ok) begin
            checkOutput({name, "_d0"}, 32'(din), 32'(ops[15:0]));
            for (int k = 1; k < BURST_LEN; k++) begin
                @(negedge clk);
                checkOutput({name, "_valid"}, 32'(valid), 32'd1);
                checkOutput({name, "_din"}, 32'(din), 32'(ops[16*k +: 16]));
            end
            @(negedge clk);
            checkOutput({name, "_end"}, 32'(valid), 32'd0);
        end
    endtask

    // Operands must come out in FIFO order, in whole bursts, each followed by the gap.
    task automatic monitor();
        logic [15:0] exp_din;
        logic        exp_done;
        logic        exp_busy;
        forever begin
            @(negedge clk);
            if (rst_prev) begin
                checkOutput("rst_valid", 32'(valid), 32'd0);
                checkOutput("rst_din", 32'(din), 32'd0);
                checkOutput("rst_busy", 32'(busy), 32'd0);
                checkOutput("rst_done", 32'(burst_done), 32'd0);
                checkOutput("rst_cnt", 32'(burst_cnt), 32'd0);
                run_len    = 0;
                low_cnt    = 0;
                tracking   = 1'b0;
                exp_bursts = 0;
                exp_word   = rd_ptr;
                exp_half   = 0;
            end else begin
                if (valid) begin
                    if (run_len == 0 && tracking) begin
                        last_gap = low_cnt;
                        checkOutput("gap_min", 32'(low_cnt >= GAP_CYCLES), 32'd1);
                    end
                    tracking = 1'b0;
                    low_cnt  = 0;
                    run_len++;
                    checkOutput("run_max", 32'(run_len <= BURST_LEN), 32'd1);
                    if (exp_word >= wr_ptr) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL din_extra: got operand 0x%0h, want none pending", din);
                    end else begin
                        exp_din = exp_half ? fifo_mem[exp_word % 64][31:16] : fifo_mem[exp_word % 64][15:0];
                        checkOutput("din", 32'(din), 32'(exp_din));
                        if (exp_half != 0) begin
                            exp_half = 0;
                            exp_word++;
                        end else begin
                            exp_half = 1;
                        end
                    end
                end else begin
                    if (run_len > 0) begin
                        checkOutput("run_len", run_len, BURST_LEN);
                        tracking = 1'b1;
                        low_cnt  = 0;
                        run_len  = 0;
                    end
                    if (tracking) low_cnt++;
                    checkOutput("din_idle", 32'(din), 32'd0);
                    if (tracking && low_cnt <= GAP_CYCLES && fifo_rd_en) gap_reads++;
                end
                exp_done = tracking && (low_cnt == GAP_CYCLES);
                if (exp_done) exp_bursts++;
                exp_busy = valid || (tracking && low_cnt <= GAP_CYCLES);
                checkOutput("burst_done", 32'(burst_done), 32'(exp_done));
                checkOutput("burst_cnt", 32'(burst_cnt), 32'(exp_bursts & 16'hFFFF));
                checkOutput("busy", 32'(busy), 32'(exp_busy));
            end
            if (rst || !enable) checkOutput("rd_gate", 32'(fifo_rd_en), 32'd0);
            checkOutput("rd_empty", 32'(fifo_rd_en && fifo_empty), 32'd0);
            rst_prev = rst;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        int n;
        int g0;

        fork
            monitor();
        join_none

        // 1: reset hold
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t1_valid", 32'(valid), 32'd0);
            checkOutput("t1_din", 32'(din), 32'd0);
            checkOutput("t1_rd_en", 32'(fifo_rd_en), 32'd0);
            checkOutput("t1_busy", 32'(busy), 32'd0);
            checkOutput("t1_done", 32'(burst_done), 32'd0);
            checkOutput("t1_cnt", 32'(burst_cnt), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        enable = 1'b1;

        // 2: single burst, gap length and counter
        applyStimulus({64'h0, 32'h0004_0003, 32'h0002_0001}, 2);
        expectBurst("t2", {16'h0004, 16'h0003, 16'h0002, 16'h0001});
        n = 1;
        while (!burst_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t2_gap_done", n, 12);
        checkOutput("t2_cnt", 32'(burst_cnt), 32'd1);
        idleCycles(5);

        // 3: partial fill stalls until the second word lands
        applyStimulus({96'h0, 32'h0006_0005}, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("t3_hold", 32'(valid), 32'd0);
        end
        applyStimulus({96'h0, 32'h0008_0007}, 1);
        expectBurst("t3", {16'h0008, 16'h0007, 16'h0006, 16'h0005});
        idleCycles(20);

        // 4: preloaded words give back-to-back bursts
        g0 = gap_reads;
        applyStimulus({32'h0008_0007, 32'h0006_0005, 32'h0004_0003, 32'h0002_0001}, 4);
        expectBurst("t4a", {16'h0004, 16'h0003, 16'h0002, 16'h0001});
        expectBurst("t4b", {16'h0008, 16'h0007, 16'h0006, 16'h0005});
        checkOutput("t4_gap", last_gap, 12);
        checkOutput("t4_gap_rd", 32'(gap_reads > g0), 32'd1);
        idleCycles(20);
        checkOutput("t4_cnt", 32'(burst_cnt), 32'd4);

        // 5: enable dropped mid-burst
        applyStimulus({64'h0, 32'h00D0_00C0, 32'h00B0_00A0}, 2);
        waitValid("t5", ok);
        if (ok) checkOutput("t5_d0", 32'(din), 32'h00A0);
        @(posedge clk);
        #1;
        enable = 1'b0;
        for (int k = 1; k < BURST_LEN; k++) begin
            @(negedge clk);
            checkOutput("t5_valid", 32'(valid), 32'd1);
        end
        @(negedge clk);
        checkOutput("t5_end", 32'(valid), 32'd0);
        applyStimulus({64'h0, 32'h5678_9ABC, 32'h0F0F_1234}, 2);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checkOutput("t5_no_rd", 32'(fifo_rd_en), 32'd0);
            checkOutput("t5_no_valid", 32'(valid), 32'd0);
        end
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_cnt", 32'(burst_cnt), 32'd5);
        @(posedge clk);
        #1;
        enable = 1'b1;
        expectBurst("t5b", {16'h5678, 16'h9ABC, 16'h0F0F, 16'h1234});
        idleCycles(20);

        // 6: reset in the third emit cycle
        applyStimulus({64'h0, 32'hCCCC_DDDD, 32'hAAAA_BBBB}, 2);
        waitValid("t6", ok);
        if (ok) checkOutput("t6_d0", 32'(din), 32'hBBBB);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_d2", 32'(din), 32'hDDDD);
        @(negedge clk);
        checkOutput("t6_valid", 32'(valid), 32'd0);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_cnt", 32'(burst_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus({64'h0, 32'h0012_0011, 32'h0010_0009}, 2);
        expectBurst("t6b", {16'h0012, 16'h0011, 16'h0010, 16'h0009});
        idleCycles(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
